// File: rtl/vhazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// vhazard_scoreboard_if : pipeline-side signal bundle for the vector hazard unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface vhazard_scoreboard_if #(
  parameter int AW   = 8,
  parameter int CNTW = 16
);
  logic [AW-1:0]   RA1E, RA2E, WA3M, WA3W;
  logic            RegWriteM, RegWriteW;
  logic [AW-1:0]   RA1D, RA2D, WA3D, WA3E, VecWAE;
  logic            RegWriteD, VecOpD, MemtoRegE, VecIssueE, BranchTakenE;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            StallF, StallD, FlushD, FlushE;
  logic            VecBusy, VecWbEn;
  logic [AW-1:0]   VecWbAddr;
  logic [CNTW-1:0] StallCnt;

  modport master (
    output RA1E, RA2E, WA3M, WA3W, RegWriteM, RegWriteW,
           RA1D, RA2D, WA3D, WA3E, VecWAE,
           RegWriteD, VecOpD, MemtoRegE, VecIssueE, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
           VecBusy, VecWbEn, VecWbAddr, StallCnt
  );

  modport slave (
    input  RA1E, RA2E, WA3M, WA3W, RegWriteM, RegWriteW,
           RA1D, RA2D, WA3D, WA3E, VecWAE,
           RegWriteD, VecOpD, MemtoRegE, VecIssueE, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
           VecBusy, VecWbEn, VecWbAddr, StallCnt
  );
endinterface

`default_nettype wire

// File: rtl/vhazard_scoreboard.sv
// ----------------------------------------------------------------------------
// vhazard_scoreboard : scalar forwarding/stall plus pending-write scoreboard
//                      for a fixed-latency, non-pipelined vector unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module vhazard_scoreboard #(
  parameter int AW   = 8,
  parameter int VLAT = 4,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vhazard_scoreboard_if.slave  hz
);

  localparam int             NREG   = 2 ** AW;
  localparam int             CW     = $clog2(VLAT + 1);
  localparam logic [CW-1:0]  C_VLAT = CW'(VLAT);
  localparam logic [CW-1:0]  C_ONE  = CW'(1);

  logic [NREG-1:0] pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wb_addr_q, wb_addr_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  logic busy, wb_en, issue_ok;
  logic hit_ra1, hit_ra2, hit_wa3;
  logic ldstall, rawstall, wawstall, structstall, stall, stall_d;

  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] ra,
    input logic [AW-1:0] wa_m, input logic we_m,
    input logic [AW-1:0] wa_w, input logic we_w
  );
    if (we_m && (wa_m == ra))      return 2'b10;
    else if (we_w && (wa_w == ra)) return 2'b01;
    else                           return 2'b00;
  endfunction

  assign hz.ForwardAE = fwd_sel(hz.RA1E, hz.WA3M, hz.RegWriteM, hz.WA3W, hz.RegWriteW);
  assign hz.ForwardBE = fwd_sel(hz.RA2E, hz.WA3M, hz.RegWriteM, hz.WA3W, hz.RegWriteW);

  assign busy     = (cnt_q != '0);
  assign wb_en    = (cnt_q == C_ONE);
  assign issue_ok = hz.VecIssueE && !busy;

  // The issuing op counts as pending in its own cycle so a dependent D-stage op stalls at once.
  assign hit_ra1 = pend_q[hz.RA1D] | (hz.VecIssueE & (hz.VecWAE == hz.RA1D));
  assign hit_ra2 = pend_q[hz.RA2D] | (hz.VecIssueE & (hz.VecWAE == hz.RA2D));
  assign hit_wa3 = pend_q[hz.WA3D] | (hz.VecIssueE & (hz.VecWAE == hz.WA3D));

  assign ldstall     = hz.MemtoRegE & ((hz.RA1D == hz.WA3E) | (hz.RA2D == hz.WA3E));
  assign rawstall    = hit_ra1 | hit_ra2;
  assign wawstall    = hz.RegWriteD & hit_wa3;
  assign structstall = hz.VecOpD & (busy | hz.VecIssueE);
  assign stall       = ldstall | rawstall | wawstall | structstall;
  assign stall_d     = stall & ~hz.BranchTakenE;

  assign hz.StallF    = stall_d;
  assign hz.StallD    = stall_d;
  assign hz.FlushD    = hz.BranchTakenE;
  assign hz.FlushE    = stall | hz.BranchTakenE;
  assign hz.VecBusy   = busy;
  assign hz.VecWbEn   = wb_en;
  assign hz.VecWbAddr = wb_addr_q;
  assign hz.StallCnt  = stall_cnt_q;

  always_comb begin
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    wb_addr_d   = wb_addr_q;
    stall_cnt_d = stall_cnt_q;

    if (busy)  cnt_d = cnt_q - C_ONE;
    if (wb_en) pend_d[wb_addr_q] = 1'b0;

    // A new issue can never coincide with write-back: the write-back cycle still reads busy.
    if (issue_ok) begin
      cnt_d             = C_VLAT;
      wb_addr_d         = hz.VecWAE;
      pend_d[hz.VecWAE] = 1'b1;
    end

    if (stall_d && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      cnt_q       <= '0;
      wb_addr_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      wb_addr_q   <= wb_addr_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vhazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_vhazard_scoreboard : scoreboard-driven bench for vhazard_scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_vhazard_scoreboard;

  localparam int AW   = 8;
  localparam int VLAT = 4;
  localparam int CNTW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vhazard_scoreboard_if #(.AW(AW), .CNTW(CNTW)) hz_if ();

  vhazard_scoreboard #(.AW(AW), .VLAT(VLAT), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz_if.slave)
  );

  typedef struct {
    logic [1:0] fa, fb;
    logic       sf, sd, fd, fe, busy;
  } exp_t;

  exp_t          exp_q[$];
  int            wb_cyc_q[$];
  logic [AW-1:0] wb_addr_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic idle();
    hz_if.RA1E = '0; hz_if.RA2E = '0; hz_if.WA3M = '0; hz_if.WA3W = '0;
    hz_if.RegWriteM = 1'b0; hz_if.RegWriteW = 1'b0;
    hz_if.RA1D = '0; hz_if.RA2D = '0; hz_if.WA3D = '0; hz_if.WA3E = '0;
    hz_if.VecWAE = '0; hz_if.RegWriteD = 1'b0; hz_if.VecOpD = 1'b0;
    hz_if.MemtoRegE = 1'b0; hz_if.VecIssueE = 1'b0; hz_if.BranchTakenE = 1'b0;
  endtask

  task automatic push_wb(input logic [AW-1:0] addr, input int at_cyc);
    wb_addr_q.push_back(addr);
    wb_cyc_q.push_back(at_cyc);
  endtask

  // Push this cycle's expectation, compare mid-cycle, then check the stall counter after the edge.
  task automatic step(input logic [1:0] fa, input logic [1:0] fb, input logic sf, input logic sd,
                      input logic fd, input logic fe, input logic busy);
    exp_t e;
    e = '{fa: fa, fb: fb, sf: sf, sd: sd, fd: fd, fe: fe, busy: busy};
    exp_q.push_back(e);
    @(negedge clk);
    e = exp_q.pop_front();
    check("ForwardAE", 32'(hz_if.ForwardAE), 32'(e.fa));
    check("ForwardBE", 32'(hz_if.ForwardBE), 32'(e.fb));
    check("StallF",    32'(hz_if.StallF),    32'(e.sf));
    check("StallD",    32'(hz_if.StallD),    32'(e.sd));
    check("FlushD",    32'(hz_if.FlushD),    32'(e.fd));
    check("FlushE",    32'(hz_if.FlushE),    32'(e.fe));
    check("VecBusy",   32'(hz_if.VecBusy),   32'(e.busy));
    if (e.sd && exp_cnt < (2 ** CNTW) - 1) exp_cnt++;
    @(posedge clk);
    #1;
    check("StallCnt", 32'(hz_if.StallCnt), 32'(exp_cnt));
  endtask

  always @(negedge clk) begin
    if (rst_n && hz_if.VecWbEn) begin
      if (wb_cyc_q.size() == 0) begin
        check("wb_unexpected", 32'(hz_if.VecWbEn), 32'd0);
      end else begin
        check("wb_addr",  32'(hz_if.VecWbAddr), 32'(wb_addr_q.pop_front()));
        check("wb_cycle", 32'(cyc),             32'(wb_cyc_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    #12;
    check("rst_VecBusy",   32'(hz_if.VecBusy),   32'd0);
    check("rst_VecWbEn",   32'(hz_if.VecWbEn),   32'd0);
    check("rst_VecWbAddr", 32'(hz_if.VecWbAddr), 32'd0);
    check("rst_StallCnt",  32'(hz_if.StallCnt),  32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Forwarding: M beats W, W used when M not writing, B port independent
    hz_if.WA3M = 8'd5; hz_if.WA3W = 8'd5; hz_if.RegWriteM = 1'b1; hz_if.RegWriteW = 1'b1; hz_if.RA1E = 8'd5;
    step(2'b10, 2'b00, 0, 0, 0, 0, 0);
    hz_if.RegWriteM = 1'b0;
    step(2'b01, 2'b00, 0, 0, 0, 0, 0);
    hz_if.RegWriteM = 1'b1; hz_if.WA3M = 8'd6; hz_if.RA2E = 8'd6;
    step(2'b01, 2'b10, 0, 0, 0, 0, 0);
    idle();

    // Load-use stall and its non-matching counterpart
    hz_if.MemtoRegE = 1'b1; hz_if.WA3E = 8'd3; hz_if.RA2D = 8'd3;
    step(2'b00, 2'b00, 1, 1, 0, 1, 0);
    hz_if.RA2D = 8'd4;
    step(2'b00, 2'b00, 0, 0, 0, 0, 0);
    idle();

    // VU RAW on RA1D
    hz_if.VecIssueE = 1'b1; hz_if.VecWAE = 8'd7; hz_if.RA1D = 8'd7;
    push_wb(8'd7, cyc + VLAT);
    step(2'b00, 2'b00, 1, 1, 0, 1, 0);
    hz_if.VecIssueE = 1'b0; hz_if.VecWAE = '0;
    for (int i = 1; i <= 4; i++) step(2'b00, 2'b00, 1, 1, 0, 1, 1);
    step(2'b00, 2'b00, 0, 0, 0, 0, 0);
    idle();

    // Structural stall with independent registers
    hz_if.VecIssueE = 1'b1; hz_if.VecWAE = 8'd9; hz_if.VecOpD = 1'b1;
    hz_if.RA1D = 8'd1; hz_if.RA2D = 8'd2; hz_if.WA3D = 8'd3; hz_if.RegWriteD = 1'b1;
    push_wb(8'd9, cyc + VLAT);
    step(2'b00, 2'b00, 1, 1, 0, 1, 0);
    hz_if.VecIssueE = 1'b0;
    for (int i = 1; i <= 4; i++) step(2'b00, 2'b00, 1, 1, 0, 1, 1);
    step(2'b00, 2'b00, 0, 0, 0, 0, 0);
    idle();

    // WAW stall, then an illegal issue while busy must be ignored
    hz_if.VecIssueE = 1'b1; hz_if.VecWAE = 8'd12; hz_if.RegWriteD = 1'b1; hz_if.WA3D = 8'd12;
    push_wb(8'd12, cyc + VLAT);
    step(2'b00, 2'b00, 1, 1, 0, 1, 0);
    hz_if.RegWriteD = 1'b0; hz_if.WA3D = '0; hz_if.VecWAE = 8'd20;
    step(2'b00, 2'b00, 0, 0, 0, 0, 1);
    hz_if.VecIssueE = 1'b0; hz_if.VecWAE = '0; hz_if.RA1D = 8'd20;
    step(2'b00, 2'b00, 0, 0, 0, 0, 1);
    hz_if.RA1D = 8'd12;
    step(2'b00, 2'b00, 1, 1, 0, 1, 1);
    step(2'b00, 2'b00, 1, 1, 0, 1, 1);
    step(2'b00, 2'b00, 0, 0, 0, 0, 0);
    hz_if.RA1D = 8'd20;
    step(2'b00, 2'b00, 0, 0, 0, 0, 0);
    idle();

    // Branch overrides a load-use stall
    hz_if.MemtoRegE = 1'b1; hz_if.WA3E = 8'd3; hz_if.RA2D = 8'd3; hz_if.BranchTakenE = 1'b1;
    step(2'b00, 2'b00, 0, 0, 1, 1, 0);
    idle();

    // Reset in cycle 2 of a VU op discards it
    hz_if.VecIssueE = 1'b1; hz_if.VecWAE = 8'd7;
    step(2'b00, 2'b00, 0, 0, 0, 0, 0);
    hz_if.VecIssueE = 1'b0; hz_if.VecWAE = '0;
    step(2'b00, 2'b00, 0, 0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    check("mid_rst_VecBusy",   32'(hz_if.VecBusy),   32'd0);
    check("mid_rst_VecWbEn",   32'(hz_if.VecWbEn),   32'd0);
    check("mid_rst_VecWbAddr", 32'(hz_if.VecWbAddr), 32'd0);
    check("mid_rst_StallCnt",  32'(hz_if.StallCnt),  32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    hz_if.RA1D = 8'd7;
    repeat (6) step(2'b00, 2'b00, 0, 0, 0, 0, 0);
    idle();

    // Stall counter saturation
    hz_if.MemtoRegE = 1'b1; hz_if.WA3E = 8'd3; hz_if.RA1D = 8'd3;
    repeat ((2 ** CNTW) + 3) step(2'b00, 2'b00, 1, 1, 0, 1, 0);
    check("StallCnt_sat", 32'(hz_if.StallCnt), 32'((2 ** CNTW) - 1));
    idle();

    repeat (2) @(posedge clk);
    check("wb_pending", 32'(wb_cyc_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
